// File: rtl/symbol_demux_loader_pkg.sv
// Shared definitions for the symbol demux loader: default symbol width, slot count
// and the loader state encoding.
package symbol_demux_loader_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int NUM_SLOTS = 4;
    localparam int PTR_W     = 2;

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } ld_state_t;

endpackage

// File: rtl/symbol_demux_loader.sv
// Collects a stream of symbols into four shadow slots and publishes whole frames
// atomically on out0..out3; HOLD defers the publish while the frame waits in shadow.
module symbol_demux_loader
    import symbol_demux_loader_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic             in_ready,
    input  logic             hold,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    ld_state_t        state, state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] idx;
    logic [WIDTH-1:0] shadow [NUM_SLOTS];

    logic accept;
    logic last_slot;
    logic commit_fill;
    logic commit_pend;
    logic commit;

    // Ready depends only on registered state, so there is no path from in_valid.
    assign in_ready = (state == FILL);
    assign accept   = in_valid & in_ready;
    assign idx      = in_sync ? '0 : wr_ptr;

    always_comb begin
        state_nxt   = state;
        last_slot   = accept && (idx == PTR_W'(NUM_SLOTS - 1));
        commit_fill = 1'b0;
        commit_pend = 1'b0;
        case (state)
            FILL: begin
                if (last_slot) begin
                    if (hold) state_nxt   = PENDING;
                    else      commit_fill = 1'b1;
                end
            end
            PENDING: begin
                if (!hold) begin
                    commit_pend = 1'b1;
                    state_nxt   = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        commit = commit_fill | commit_pend;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= FILL;
            wr_ptr     <= '0;
            out0       <= RESET_VAL;
            out1       <= RESET_VAL;
            out2       <= RESET_VAL;
            out3       <= RESET_VAL;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= RESET_VAL;
        end else begin
            state      <= state_nxt;
            frame_done <= commit;
            if (commit) frame_cnt <= frame_cnt + 1'b1;

            // A sync symbol rewinds to slot0, which silently discards a partial frame.
            if (accept) begin
                shadow[idx] <= in_data;
                wr_ptr      <= idx + 1'b1;
            end

            // Streaming publish bypasses shadow[3] so there is no stall cycle.
            if (commit_fill) begin
                out0 <= shadow[0];
                out1 <= shadow[1];
                out2 <= shadow[2];
                out3 <= in_data;
            end else if (commit_pend) begin
                out0 <= shadow[0];
                out1 <= shadow[1];
                out2 <= shadow[2];
                out3 <= shadow[3];
            end
        end
    end

endmodule

// File: tb/tb_symbol_demux_loader.sv
// Directed bench for symbol_demux_loader: streaming, hold/pending, resync, gapped
// input, frame counter wrap and reset while a frame is pending.
module tb_symbol_demux_loader;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sync;
    logic             in_ready;
    logic             hold;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt;

    int total;
    int passed;
    int ready_low;

    symbol_demux_loader #(.WIDTH(WIDTH), .RESET_VAL('0), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_ready   (in_ready),
        .hold       (hold),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d);
        chk({tag, ".out0"}, 32'(out0), 32'(a));
        chk({tag, ".out1"}, 32'(out1), 32'(b));
        chk({tag, ".out2"}, 32'(out2), 32'(c));
        chk({tag, ".out3"}, 32'(out3), 32'(d));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] d, input logic s);
        in_data  = d;
        in_sync  = s;
        in_valid = 1'b1;
        if (!in_ready) ready_low++;
        step();
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic frame(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [4:0] d, input bit gaps);
        send(a, 1'b1);
        if (gaps) step();
        send(b, 1'b0);
        if (gaps) step();
        send(c, 1'b0);
        if (gaps) step();
        send(d, 1'b0);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        ready_low = 0;
        resetn    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        hold      = 1'b0;
        step();
        step();

        // Reset state
        chk_outs("rst", 5'h00, 5'h00, 5'h00, 5'h00);
        chk("rst.ready", 32'(in_ready), 32'd1);
        chk("rst.cnt", 32'(frame_cnt), 32'd0);
        chk("rst.done", 32'(frame_done), 32'd0);
        resetn = 1'b1;
        step();

        // Zero-stall streaming frame
        send(5'h01, 1'b1);
        chk("s1.done0", 32'(frame_done), 32'd0);
        send(5'h02, 1'b0);
        send(5'h03, 1'b0);
        chk_outs("s1.pre", 5'h00, 5'h00, 5'h00, 5'h00);
        send(5'h04, 1'b0);
        chk_outs("s1", 5'h01, 5'h02, 5'h03, 5'h04);
        chk("s1.done", 32'(frame_done), 32'd1);
        chk("s1.cnt", 32'(frame_cnt), 32'd1);
        chk("s1.readylow", 32'(ready_low), 32'd0);
        step();
        chk("s1.donepulse", 32'(frame_done), 32'd0);

        // Hold: frame parks in shadow, loader stalls
        hold = 1'b1;
        frame(5'h0A, 5'h0B, 5'h0C, 5'h0D, 1'b0);
        chk_outs("h.frozen", 5'h01, 5'h02, 5'h03, 5'h04);
        chk("h.ready", 32'(in_ready), 32'd0);
        chk("h.done", 32'(frame_done), 32'd0);
        in_valid = 1'b1;
        in_data  = 5'h1F;
        for (int i = 0; i < 5; i++) step();
        chk_outs("h.wait", 5'h01, 5'h02, 5'h03, 5'h04);
        chk("h.waitready", 32'(in_ready), 32'd0);
        chk("h.waitcnt", 32'(frame_cnt), 32'd1);
        in_valid = 1'b0;
        hold     = 1'b0;
        step();
        chk_outs("h.pub", 5'h0A, 5'h0B, 5'h0C, 5'h0D);
        chk("h.done", 32'(frame_done), 32'd1);
        chk("h.ready1", 32'(in_ready), 32'd1);
        chk("h.cnt", 32'(frame_cnt), 32'd2);

        // Pointer must be back at slot0: frame without any sync
        send(5'h05, 1'b0);
        send(5'h06, 1'b0);
        send(5'h07, 1'b0);
        send(5'h08, 1'b0);
        chk_outs("nosync", 5'h05, 5'h06, 5'h07, 5'h08);
        chk("nosync.cnt", 32'(frame_cnt), 32'd3);

        // Resync mid-frame discards the partial frame
        send(5'h11, 1'b1);
        send(5'h12, 1'b0);
        send(5'h15, 1'b1);
        chk("rs.done0", 32'(frame_done), 32'd0);
        send(5'h16, 1'b0);
        send(5'h17, 1'b0);
        chk("rs.done1", 32'(frame_done), 32'd0);
        chk_outs("rs.pre", 5'h05, 5'h06, 5'h07, 5'h08);
        send(5'h18, 1'b0);
        chk_outs("rs", 5'h15, 5'h16, 5'h17, 5'h18);
        chk("rs.done", 32'(frame_done), 32'd1);
        chk("rs.cnt", 32'(frame_cnt), 32'd4);
        step();
        chk("rs.donepulse", 32'(frame_done), 32'd0);

        // Gapped input across three frames
        frame(5'h00, 5'h01, 5'h02, 5'h03, 1'b1);
        chk_outs("g1", 5'h00, 5'h01, 5'h02, 5'h03);
        step();
        frame(5'h1C, 5'h1D, 5'h1E, 5'h1F, 1'b1);
        chk_outs("g2", 5'h1C, 5'h1D, 5'h1E, 5'h1F);
        step();
        frame(5'h09, 5'h10, 5'h13, 5'h14, 1'b1);
        chk_outs("g3", 5'h09, 5'h10, 5'h13, 5'h14);
        chk("g.cnt", 32'(frame_cnt), 32'd7);

        // Counter wrap: 248 more frames -> 255, one more -> 0
        for (int f = 0; f < 248; f++) frame(5'(f), 5'(f + 1), 5'(f + 2), 5'(f + 3), 1'b0);
        chk("w.cnt255", 32'(frame_cnt), 32'd255);
        frame(5'h02, 5'h04, 5'h06, 5'h08, 1'b0);
        chk("w.cnt0", 32'(frame_cnt), 32'd0);
        chk("w.done", 32'(frame_done), 32'd1);
        chk_outs("w", 5'h02, 5'h04, 5'h06, 5'h08);
        chk("w.readylow", 32'(ready_low), 32'd0);
        step();

        // Reset while a frame is pending
        hold = 1'b1;
        frame(5'h1A, 5'h1B, 5'h1C, 5'h1D, 1'b0);
        chk("rp.ready", 32'(in_ready), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk_outs("rp.rst", 5'h00, 5'h00, 5'h00, 5'h00);
        chk("rp.rstready", 32'(in_ready), 32'd1);
        chk("rp.rstcnt", 32'(frame_cnt), 32'd0);
        step();
        resetn = 1'b1;
        hold   = 1'b0;
        step();
        step();
        chk_outs("rp.lost", 5'h00, 5'h00, 5'h00, 5'h00);
        chk("rp.done", 32'(frame_done), 32'd0);
        chk("rp.cnt", 32'(frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
